// File: rtl/ysyx_22050019_pipe_stage_reg_pkg.sv
// Shared pipeline payload layout: IF/ID field offsets, per-stage payload widths
// and the NOP used as the reset/flush payload of the fetch stage.
package ysyx_22050019_pipe_stage_reg_pkg;

  localparam int INST_LSB   = 0;
  localparam int INST_MSB   = 31;
  localparam int PC_LSB     = 32;
  localparam int PC_MSB     = 95;
  localparam int COMMIT_BIT = 96;

  localparam int IFID_W  = 97;
  localparam int IDEX_W  = 97;
  localparam int EXMEM_W = 97;
  localparam int MEMWB_W = 97;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic        commit;
    logic [63:0] pc;
    logic [31:0] inst;
  } ifid_t;

  localparam logic [IFID_W-1:0] IFID_NOP = {1'b0, 64'h0, NOP_INST};

  function automatic logic [IFID_W-1:0] pack_ifid(input logic        commit,
                                                  input logic [63:0] pc,
                                                  input logic [31:0] inst);
    ifid_t p;
    p.commit = commit;
    p.pc     = pc;
    p.inst   = inst;
    return p;
  endfunction

endpackage

// File: rtl/ysyx_22050019_pipe_slot.sv
// One valid+payload register. clear wins over load, load wins over drop;
// drop only invalidates, so a released payload stays visible but stale.
module ysyx_22050019_pipe_slot #(
  parameter int                DATA_W   = 97,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= RST_DATA;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= RST_DATA;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end else if (drop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ysyx_22050019_pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and an
// optional skid slot that keeps in_ready_o free of any path from out_ready_i.
module ysyx_22050019_pipe_stage_reg
  import ysyx_22050019_pipe_stage_reg_pkg::*;
#(
  parameter int                DATA_W   = IFID_W,
  parameter bit                SKID     = 1'b1,
  parameter logic [DATA_W-1:0] RST_DATA = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
);

  logic              accept;
  logic              rel;
  logic              main_valid;
  logic              main_load;
  logic              main_drop;
  logic [DATA_W-1:0] main_d;
  logic              skid_valid;

  assign accept = in_valid_i & in_ready_o;
  assign rel    = main_valid & out_ready_i;

  generate
    if (SKID) begin : g_skid
      logic              skid_load;
      logic [DATA_W-1:0] skid_data;

      // in_ready_o comes straight from the skid valid flop
      assign in_ready_o = !skid_valid;
      // The skid entry always drains into main before new input is taken
      assign main_load  = (accept & (!main_valid | rel)) | (skid_valid & rel);
      assign main_d     = skid_valid ? skid_data : in_data_i;
      assign main_drop  = rel;
      assign skid_load  = accept & main_valid & !rel;

      ysyx_22050019_pipe_slot #(
        .DATA_W   (DATA_W),
        .RST_DATA (RST_DATA)
      ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (flush_i),
        .load  (skid_load),
        .drop  (rel),
        .d     (in_data_i),
        .valid (skid_valid),
        .data  (skid_data)
      );
    end else begin : g_single
      assign in_ready_o = !main_valid | out_ready_i;
      assign main_load  = accept;
      assign main_d     = in_data_i;
      assign main_drop  = rel;
      assign skid_valid = 1'b0;
    end
  endgenerate

  ysyx_22050019_pipe_slot #(
    .DATA_W   (DATA_W),
    .RST_DATA (RST_DATA)
  ) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush_i),
    .load  (main_load),
    .drop  (main_drop),
    .d     (main_d),
    .valid (main_valid),
    .data  (out_data_o)
  );

  assign out_valid_o = main_valid;
  assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_ysyx_22050019_pipe_stage_reg.sv
// Bench for the stage register: one SKID=0 and one SKID=1 instance, exercised
// through vector tables, hand sequences and a random run against a queue model.
module tb_ysyx_22050019_pipe_stage_reg;

  localparam int W = 16;

  typedef struct packed {
    logic         iv;
    logic [W-1:0] id;
    logic         r;
    logic         f;
    logic         eov;
    logic [W-1:0] eod;
    logic [1:0]   eocc;
    logic         eir;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         iv   [2];
  logic         ir   [2];
  logic         ov   [2];
  logic         ordy [2];
  logic         fl   [2];
  logic [W-1:0] id   [2];
  logic [W-1:0] od   [2];
  logic [1:0]   occ  [2];

  int           n_chk  = 0;
  int           n_fail = 0;
  int           cur    = 1;
  logic [W-1:0] mq[$];
  bit           zflag  = 1'b1;

  always #5 clk = ~clk;

  ysyx_22050019_pipe_stage_reg #(.DATA_W(W), .SKID(1'b0), .RST_DATA('0)) u_s0 (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (fl[0]),
    .in_valid_i  (iv[0]),
    .in_ready_o  (ir[0]),
    .in_data_i   (id[0]),
    .out_valid_o (ov[0]),
    .out_ready_i (ordy[0]),
    .out_data_o  (od[0]),
    .occupancy_o (occ[0])
  );

  ysyx_22050019_pipe_stage_reg #(.DATA_W(W), .SKID(1'b1), .RST_DATA('0)) u_s1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (fl[1]),
    .in_valid_i  (iv[1]),
    .in_ready_o  (ir[1]),
    .in_data_i   (id[1]),
    .out_valid_o (ov[1]),
    .out_ready_i (ordy[1]),
    .out_data_o  (od[1]),
    .occupancy_o (occ[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (dut SKID=%0d): got %0h expected %0h at %0t", nm, cur, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic r,
                              input logic f, input logic eov, input logic [W-1:0] eod,
                              input logic [1:0] eocc, input logic eir);
    vec_t t;
    t.iv = v; t.id = d; t.r = r; t.f = f;
    t.eov = eov; t.eod = eod; t.eocc = eocc; t.eir = eir;
    return t;
  endfunction

  // Drive one cycle on the active DUT, compare against the queue model (and the
  // vector's explicit expectations), then advance the model on the clock edge.
  task automatic cycle(input vec_t v, input bit has_exp);
    logic         acc;
    logic         rel;
    logic [W-1:0] tmp;
    bit           exp_ir;
    @(negedge clk);
    iv[cur] = v.iv; id[cur] = v.id; ordy[cur] = v.r; fl[cur] = v.f;
    #1;
    exp_ir = (cur == 1) ? (mq.size() < 2) : ((mq.size() == 0) || v.r);
    chk("sb_out_valid", 32'(ov[cur]), 32'(mq.size() > 0));
    chk("sb_occupancy", 32'(occ[cur]), 32'(mq.size()));
    chk("sb_in_ready", 32'(ir[cur]), 32'(exp_ir));
    if (mq.size() > 0) chk("sb_out_data", 32'(od[cur]), 32'(mq[0]));
    else if (zflag) chk("sb_flushed_data", 32'(od[cur]), 32'h0);
    if (has_exp) begin
      chk("vec_out_valid", 32'(ov[cur]), 32'(v.eov));
      chk("vec_out_data", 32'(od[cur]), 32'(v.eod));
      chk("vec_occupancy", 32'(occ[cur]), 32'(v.eocc));
      chk("vec_in_ready", 32'(ir[cur]), 32'(v.eir));
    end
    acc = v.iv & ir[cur];
    rel = ov[cur] & v.r;
    @(posedge clk);
    if (rel && mq.size() > 0) tmp = mq.pop_front();
    if (v.f) begin
      mq.delete();
      zflag = 1'b1;
    end else if (acc) begin
      mq.push_back(v.id);
      zflag = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    for (int d = 0; d < 2; d++) begin
      cur = d;
      chk({nm, "_out_valid"}, 32'(ov[d]), 32'h0);
      chk({nm, "_occupancy"}, 32'(occ[d]), 32'h0);
      chk({nm, "_out_data"}, 32'(od[d]), 32'h0);
      chk({nm, "_in_ready"}, 32'(ir[d]), 32'h1);
    end
  endtask

  vec_t t1[14];
  vec_t t0[8];

  initial begin
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; id[d] = '0; ordy[d] = 1'b0; fl[d] = 1'b0;
    end

    // SKID=1: backpressure, drain order, flush in FULL and flush with accept+release
    t1[0]  = mk(1'b1, 16'h000A, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1);
    t1[1]  = mk(1'b1, 16'h000B, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd1, 1'b1);
    t1[2]  = mk(1'b1, 16'h000D, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd2, 1'b0);
    t1[3]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h000A, 2'd2, 1'b0);
    t1[4]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h000A, 2'd2, 1'b0);
    t1[5]  = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h000B, 2'd1, 1'b1);
    t1[6]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h000B, 2'd0, 1'b1);
    t1[7]  = mk(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h000B, 2'd0, 1'b1);
    t1[8]  = mk(1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0001, 2'd1, 1'b1);
    t1[9]  = mk(1'b1, 16'h000C, 1'b0, 1'b1, 1'b1, 16'h0001, 2'd2, 1'b0);
    t1[10] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1);
    t1[11] = mk(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1);
    t1[12] = mk(1'b1, 16'h000C, 1'b1, 1'b1, 1'b1, 16'h0005, 2'd1, 1'b1);
    t1[13] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1);

    // SKID=0: combinational ready, replace-on-release, flush discarding an accept
    t0[0] = mk(1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1);
    t0[1] = mk(1'b1, 16'h0008, 1'b0, 1'b0, 1'b1, 16'h0007, 2'd1, 1'b0);
    t0[2] = mk(1'b1, 16'h0008, 1'b1, 1'b0, 1'b1, 16'h0007, 2'd1, 1'b1);
    t0[3] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0008, 2'd1, 1'b0);
    t0[4] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0008, 2'd1, 1'b1);
    t0[5] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0008, 2'd0, 1'b1);
    t0[6] = mk(1'b1, 16'h0009, 1'b1, 1'b1, 1'b0, 16'h0008, 2'd0, 1'b1);
    t0[7] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    cur = 1; mq.delete(); zflag = 1'b1;
    for (int i = 0; i < 14; i++) cycle(t1[i], 1'b1);

    for (int i = 1; i <= 20; i++)
      cycle(mk(1'b1, W'(i), 1'b1, 1'b0, 1'b1, W'(i - 1), 2'd1, 1'b1), i > 1);
    cycle(mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'd20, 2'd1, 1'b1), 1'b1);

    // Reset asserted between clocks while FULL, then held across an edge
    cycle(mk(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1), 1'b0);
    cycle(mk(1'b1, 16'h00BB, 1'b0, 1'b0, 1'b1, 16'h00AA, 2'd1, 1'b1), 1'b1);
    cycle(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h00AA, 2'd2, 1'b0), 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    @(negedge clk);
    rst_n = 1'b1;

    cur = 0; mq.delete(); zflag = 1'b1;
    for (int i = 0; i < 8; i++) cycle(t0[i], 1'b1);

    for (int d = 0; d < 2; d++) begin
      logic [W-1:0] seq;
      cur = 1 - d;
      mq.delete();
      zflag = (cur == 1);
      if (cur == 0) begin
        // SKID=0 instance holds stale data 0 only after its last flush
        zflag = 1'b1;
      end
      seq = 16'h0100;
      for (int n = 0; n < 5000; n++) begin
        logic v;
        v = 1'($urandom_range(0, 1));
        cycle(mk(v, seq, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                 1'b0, 16'h0, 2'd0, 1'b0), 1'b0);
        if (v) seq = seq + 16'd1;
      end
      cycle(mk(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0, 2'd0, 1'b0), 1'b0);
      cycle(mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0, 2'd0, 1'b0), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
